// File: rtl/alu32_seq.sv
// alu32_seq: 32-bit ALU that reuses one 16-bit datapath over two cycles (low half, then high half).
// Define ALU32_SEQ_FLAGS_EN to register {N,Z,C,V}; otherwise out_flags is tied to zero.
`default_nettype none

module alu16 (
  input  logic [2:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] res_o,
  output logic        cout_o
);
  logic [15:0] bx;
  logic [16:0] sum;

  always_comb begin
    // Subtract is a + ~b + cin, with cin=1 on the low half.
    bx     = (op_i == 3'b011) ? ~b_i : b_i;
    sum    = {1'b0, a_i} + {1'b0, bx} + {16'b0, cin_i};
    res_o  = b_i;
    cout_o = 1'b0;
    case (op_i)
      3'b010, 3'b011: {cout_o, res_o} = sum;
      3'b100:         res_o = a_i & b_i;
      3'b101:         res_o = a_i | b_i;
      3'b110:         res_o = a_i ^ b_i;
      default:        res_o = b_i;
    endcase
  end
endmodule

module alu32_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_cout,
  output logic [3:0]  out_flags
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [15:0] res_lo_q;
  logic        carry_lo_q;
  logic [31:0] result_q;
  logic        cout_q;

  logic        accept;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout;

  assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_cout   = cout_q;

  assign alu_a   = (state_q == HI) ? a_q[31:16] : a_q[15:0];
  assign alu_b   = (state_q == HI) ? b_q[31:16] : b_q[15:0];
  assign alu_cin = (state_q == HI) ? carry_lo_q : op_q[0];

  alu16 u_alu16 (
    .op_i   (op_q),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .cin_i  (alu_cin),
    .res_o  (alu_res),
    .cout_o (alu_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = HI;
      HI:      state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 3'b000;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      res_lo_q   <= 16'h0;
      carry_lo_q <= 1'b0;
      result_q   <= 32'h0;
      cout_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      if (state_q == LO) begin
        res_lo_q   <= alu_res;
        carry_lo_q <= alu_cout;
      end
      // Visible result only changes at the HI edge, so it holds through the next LO.
      if (state_q == HI) begin
        result_q <= {alu_res, res_lo_q};
        cout_q   <= alu_cout;
      end
    end
  end

`ifdef ALU32_SEQ_FLAGS_EN
  logic [3:0] flags_q;
  logic       is_arith, bx_msb, ovf, zero;

  assign is_arith  = (op_q == 3'b010) || (op_q == 3'b011);
  assign bx_msb    = b_q[31] ^ (op_q == 3'b011);
  assign ovf       = is_arith && (a_q[31] == bx_msb) && (alu_res[15] != a_q[31]);
  assign zero      = ({alu_res, res_lo_q} == 32'h0);
  assign out_flags = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (state_q == HI) begin
      flags_q <= {alu_res[15], zero, alu_cout, ovf};
    end
  end
`else
  assign out_flags = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu32_seq.sv
// Directed self-checking bench for alu32_seq; flag expectations follow ALU32_SEQ_FLAGS_EN.
`default_nettype none

module tb_alu32_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
  logic [3:0]  out_flags;

  int errors = 0;
  int checks = 0;

  alu32_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request, lets it be taken at the next edge, then scrambles the operands.
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_a     = ~a;
    in_b     = ~b;
  endtask

  // Counts edges from the accept edge (counted as 1) until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", out_result); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
    checks++; if (out_flags !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ops(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_c, input logic [3:0] exp_f_full);
    int lat;
    logic [3:0] exp_f;
`ifdef ALU32_SEQ_FLAGS_EN
    exp_f = exp_f_full;
`else
    exp_f = 4'b0000;
`endif
    accept(op, a, b);
    wait_valid(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL %s_latency got=%0d exp=3", name, lat); end
    checks++; if (out_result !== exp_res) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, out_result, exp_res); end
    checks++; if (out_cout !== exp_c) begin errors++; $display("FAIL %s_cout got=%b exp=%b", name, out_cout, exp_c); end
    checks++; if (out_flags !== exp_f) begin errors++; $display("FAIL %s_flags got=%b exp=%b", name, out_flags, exp_f); end
  endtask

  task automatic test_arith;
    out_ready = 1'b1;
    test_ops("add_carry16", 3'b010, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 4'b0000);
    test_ops("add_ovf",     3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 4'b1001);
    test_ops("sub_equal",   3'b011, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 4'b0110);
    test_ops("sub_borrow",  3'b011, 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hDDDDDDDE, 1'b0, 4'b1000);
    test_ops("add_wrap",    3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 4'b0110);
    test_ops("sub_small",   3'b011, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1, 4'b0010);
    test_ops("sub_ovf",     3'b011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 4'b0011);
  endtask

  task automatic test_logic;
    out_ready = 1'b1;
    test_ops("and",     3'b100, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 4'b0000);
    test_ops("or",      3'b101, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 4'b0000);
    test_ops("xor",     3'b110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 4'b1000);
    test_ops("pass_b",  3'b000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'b1000);
    test_ops("op001",   3'b001, 32'hFFFFFFFF, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 4'b1000);
    test_ops("op111",   3'b111, 32'hFFFFFFFF, 32'h13579BDF, 32'h13579BDF, 1'b0, 4'b0000);
    test_ops("and_zero",3'b100, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b0, 4'b0100);
  endtask

  task automatic test_back_to_back;
    int lat;
    // Drain to IDLE, then check the held result outside DONE.
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'h00000000) begin errors++; $display("FAIL idle_hold got=%h exp=00000000", out_result); end
    out_ready = 1'b0;
    accept(3'b010, 32'h0000FFFF, 32'h00000001);
    // Requests while busy must be ignored.
    in_valid = 1'b1; in_op = 3'b100; in_a = 32'h0; in_b = 32'h0;
    wait_valid(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got=%0d exp=3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h00010000 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d valid=%b result=%h ready=%b exp=1/00010000/0", i, out_valid, out_result, in_ready); end
    end
    in_op = 3'b110; in_a = 32'hFFFF0000; in_b = 32'h0F0F0F0F; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h00010000)
      begin errors++; $display("FAIL b2b_lo valid=%b result=%h exp=0/00010000", out_valid, out_result); end
    wait_valid(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    checks++; if (out_result !== 32'hF0F00F0F || out_cout !== 1'b0)
      begin errors++; $display("FAIL b2b_result got=%h/%b exp=f0f00f0f/0", out_result, out_cout); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    accept(3'b010, 32'hFFFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_cout !== 1'b0 || out_flags !== 4'b0)
      begin errors++; $display("FAIL rstmid_out valid=%b result=%h cout=%b flags=%b exp=all 0", out_valid, out_result, out_cout, out_flags); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_cout !== 1'b0)
        begin errors++; $display("FAIL rstmid_quiet%0d valid=%b result=%h cout=%b exp=0", i, out_valid, out_result, out_cout); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_a      = 32'h0;
    in_b      = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_arith();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
